bus_addr_ctrl: RTL

Parametrised, registered bus address decoder and transaction controller. Sits between the single bus master and the slave bank (matrix unit, RAM A/B/C, plus future slaves). Per request, it decodes the top address bits to a one-hot slave select and holds the select until the selected slave acknowledges. It returns a one-cycle ack or error pulse to the master and maintains a saturating error count.

---
 rtl/bus_addr_pkg.sv | 22 ++
 rtl/bus_addr_timer.sv | 28 ++
 rtl/bus_addr_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/bus_addr_pkg.sv
// Shared FSM type, region indices and error-counter helpers for bus_addr_ctrl.
package bus_addr_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   localparam int REG_MATRIX = 0;
   localparam int REG_RAM_A  = 1;
   localparam int REG_RAM_B  = 2;
   localparam int REG_RAM_C  = 3;

   localparam int ERR_CNT_W = 8;

   // Count up, holding at all-ones instead of wrapping.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + ERR_CNT_W'(1);
   endfunction

endpackage

// File: rtl/bus_addr_timer.sv
// ACCESS-phase wait timer: counts enabled cycles and flags the last one before timeout.
module bus_addr_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   // Qualified by enable so a same-cycle ack always beats the timeout.
   assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_addr_ctrl.sv
// Registered bus address decoder and single-outstanding transaction controller.
// Define BUS_ADDR_TIMEOUT_EN to include the ACCESS timeout timer and its error path.
module bus_addr_ctrl
   import bus_addr_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int REGION_W   = 3,
   parameter int NUM_SLAVES = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  m_req,
   input  logic [ADDR_W-1:0]     m_addr,
   output logic                  m_ack,
   output logic                  m_err,
   output logic [NUM_SLAVES-1:0] s_sel,
   input  logic [NUM_SLAVES-1:0] s_ack,
   output logic                  busy,
   output logic [ERR_CNT_W-1:0]  err_cnt
);

   if (NUM_SLAVES < 1 || NUM_SLAVES > (1 << REGION_W) || TIMEOUT < 1 ||
       REGION_W > ADDR_W) begin : g_param_check
      $error("bus_addr_ctrl: illegal parameter combination");
   end

   state_t              state;
   logic [REGION_W-1:0] region;
   logic                mapped;
   logic                hit;
   logic                timeout;
   logic                unused_addr_bits;

   assign region           = m_addr[ADDR_W-1 -: REGION_W];
   assign mapped           = int'(region) < NUM_SLAVES;
   assign unused_addr_bits = ^m_addr[ADDR_W-REGION_W-1:0];

   // s_sel holds the latched region as a one-hot, so masking s_ack with it
   // selects the addressed slave's ack and discards all others.
   assign hit = |(s_ack & s_sel);

`ifdef BUS_ADDR_TIMEOUT_EN
   bus_addr_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state != ACCESS),
      .enable  (state == ACCESS && !hit),
      .expired (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         s_sel   <= '0;
         m_ack   <= 1'b0;
         m_err   <= 1'b0;
         busy    <= 1'b0;
         err_cnt <= '0;
      end else begin
         m_ack <= 1'b0;
         m_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (m_req) begin
                  busy <= 1'b1;
                  if (mapped) begin
                     s_sel <= NUM_SLAVES'(1) << region;
                     state <= ACCESS;
                  end else begin
                     m_err   <= 1'b1;
                     err_cnt <= sat_inc(err_cnt);
                     state   <= RESP;
                  end
               end
            end
            ACCESS: begin
               if (hit) begin
                  s_sel <= '0;
                  m_ack <= 1'b1;
                  state <= RESP;
               end else if (timeout) begin
                  s_sel   <= '0;
                  m_err   <= 1'b1;
                  err_cnt <= sat_inc(err_cnt);
                  state   <= RESP;
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               s_sel <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
